// File: rtl/mem_access_stage_if.sv
// Data-memory request/ack bus between the memory-access stage and the data memory.
// Latency: none (wires only).
// Backpressure: the memory holds off completion by keeping DM_ack low while DM_req is high.
interface mem_access_stage_if;
    logic        DM_req;
    logic        DM_we;
    logic [31:0] DM_addr;
    logic [3:0]  DM_be;
    logic [31:0] DM_wdata;
    logic        DM_ack;
    logic [31:0] DM_rdata;

    // Stage side: issues requests, receives completion and read data.
    modport master (
        output DM_req,
        output DM_we,
        output DM_addr,
        output DM_be,
        output DM_wdata,
        input  DM_ack,
        input  DM_rdata
    );

    // Memory side: accepts requests, returns completion and read data.
    modport slave (
        input  DM_req,
        input  DM_we,
        input  DM_addr,
        input  DM_be,
        input  DM_wdata,
        output DM_ack,
        output DM_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access stage: EX/M load/store controls -> req/ack data-memory transaction, load formatting, M_WB drive.
// Latency: 1 cycle for non-memory ops; 3 + (BUSY cycles before ack) - 1 for an aligned memory access.
// Backpressure: mem_stall freezes the upstream pipe from the issue cycle until DONE; DM_ack stalls BUSY up to TIMEOUT cycles.
module mem_access_stage #(
    parameter int data_size = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 M_MemRead,
    input  logic                 M_MemWrite,
    input  logic                 M_MemtoReg,
    input  logic                 M_RegWrite,
    input  logic [1:0]           M_Size,
    input  logic                 M_Unsigned,
    input  logic [data_size-1:0] M_ALU_out,
    input  logic [data_size-1:0] M_Rt_data,
    input  logic [4:0]           M_WR,
    mem_access_stage_if.master   dm,
    output logic                 M_WBWrite,
    output logic                 M_WB_MemtoReg,
    output logic                 M_WB_RegWrite,
    output logic [data_size-1:0] M_DM_Read_Data,
    output logic [data_size-1:0] M_WD_out,
    output logic [4:0]           M_WR_out,
    output logic                 mem_stall,
    output logic                 mem_fault,
    output logic [1:0]           fault_cause
);

    // Counter only needs to reach TIMEOUT-1; TIMEOUT >= 2 keeps the width at least one bit.
    localparam int                CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_MISALGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              err;

    // Access shape captured at issue so load formatting does not depend on EX/M staying frozen.
    logic [1:0]        size_q;
    logic [1:0]        lane_q;
    logic              uns_q;

    logic              mem_op;
    logic              mis_addr;
    logic              misaligned;
    logic              issue;
    logic [3:0]        be_next;
    logic [31:0]       wdata_next;
    logic [31:0]       load_fmt;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;

    // Request decode: alignment check, byte enables and lane-replicated store data.
    always_comb begin
        mem_op     = M_MemRead | M_MemWrite;
        mis_addr   = 1'b0;
        be_next    = 4'b1111;
        wdata_next = M_Rt_data;
        case (M_Size)
            SZ_HALF: begin
                mis_addr   = M_ALU_out[0];
                be_next    = M_ALU_out[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{M_Rt_data[15:0]}};
            end
            SZ_BYTE: begin
                mis_addr   = 1'b0;
                be_next    = 4'b0001 << M_ALU_out[1:0];
                wdata_next = {4{M_Rt_data[7:0]}};
            end
            default: begin
                // 00 and the unused 11 encoding are both full-word accesses.
                mis_addr   = |M_ALU_out[1:0];
                be_next    = 4'b1111;
                wdata_next = M_Rt_data;
            end
        endcase
        misaligned = mem_op & mis_addr;
        issue      = mem_op & ~mis_addr;
    end

    // Load formatter: pick the addressed lane(s) and sign- or zero-extend.
    always_comb begin
        case (lane_q)
            2'd0:    rd_byte = dm.DM_rdata[7:0];
            2'd1:    rd_byte = dm.DM_rdata[15:8];
            2'd2:    rd_byte = dm.DM_rdata[23:16];
            default: rd_byte = dm.DM_rdata[31:24];
        endcase
        rd_half = lane_q[1] ? dm.DM_rdata[31:16] : dm.DM_rdata[15:0];
        case (size_q)
            SZ_BYTE: load_fmt = {{24{~uns_q & rd_byte[7]}}, rd_byte};
            SZ_HALF: load_fmt = {{16{~uns_q & rd_half[15]}}, rd_half};
            default: load_fmt = dm.DM_rdata;
        endcase
    end

    // Transaction FSM with registered memory-bus outputs and load result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            cnt            <= '0;
            err            <= 1'b0;
            size_q         <= 2'b00;
            lane_q         <= 2'b00;
            uns_q          <= 1'b0;
            dm.DM_req      <= 1'b0;
            dm.DM_we       <= 1'b0;
            dm.DM_addr     <= '0;
            dm.DM_be       <= '0;
            dm.DM_wdata    <= '0;
            M_DM_Read_Data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        // A set MemWrite wins when both read and write are requested.
                        dm.DM_req   <= 1'b1;
                        dm.DM_we    <= M_MemWrite;
                        dm.DM_addr  <= {M_ALU_out[31:2], 2'b00};
                        dm.DM_be    <= be_next;
                        dm.DM_wdata <= wdata_next;
                        size_q      <= M_Size;
                        lane_q      <= M_ALU_out[1:0];
                        uns_q       <= M_Unsigned;
                        cnt         <= '0;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    // Ack is checked first so a completion on the last allowed cycle is not a fault.
                    if (dm.DM_ack) begin
                        dm.DM_req <= 1'b0;
                        if (!dm.DM_we) begin
                            M_DM_Read_Data <= load_fmt;
                        end
                        state <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        dm.DM_req <= 1'b0;
                        err       <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    err   <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    dm.DM_req <= 1'b0;
                    err       <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Pipeline control: stall while a transaction is pending, report faults in the advance cycle.
    always_comb begin
        mem_stall   = 1'b0;
        M_WBWrite   = 1'b1;
        mem_fault   = 1'b0;
        fault_cause = CAUSE_NONE;
        case (state)
            IDLE: begin
                if (issue) begin
                    mem_stall = 1'b1;
                    M_WBWrite = 1'b0;
                end else if (misaligned) begin
                    mem_fault   = 1'b1;
                    fault_cause = CAUSE_MISALGN;
                end
            end
            BUSY: begin
                mem_stall = 1'b1;
                M_WBWrite = 1'b0;
            end
            DONE: begin
                if (err) begin
                    mem_fault   = 1'b1;
                    fault_cause = CAUSE_TIMEOUT;
                end
            end
            default: begin
                mem_stall = 1'b0;
                M_WBWrite = 1'b1;
            end
        endcase
    end

    // A faulting instruction still advances but must not write the register file.
    assign M_WB_RegWrite = M_RegWrite & ~mem_fault;
    assign M_WB_MemtoReg = M_MemtoReg;
    assign M_WD_out      = M_ALU_out;
    assign M_WR_out      = M_WR;

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access stage logic between the EX/M pipeline register and the M_WB pipeline register.
- Turns the EX/M load/store controls into a req/ack transaction on a variable-latency data memory.
- Formats load data for byte, half and word accesses, with sign or zero extension.
- Stalls the upstream pipe while a transaction is outstanding. Drives M_WB's write enable and inputs.
- Flags misaligned accesses and memory timeouts.

Parameters:
- data_size, 32, datapath width; only 32 is supported.
- TIMEOUT, 16, maximum BUSY cycles to wait for DM_ack before aborting; must be at least 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- M_MemRead  in  1  load request.
- M_MemWrite  in  1  store request.
- M_MemtoReg  in  1  writeback selects memory data.
- M_RegWrite  in  1  instruction writes the register file.
- M_Size  in  2  access size: 00 word, 01 half, 10 byte; 11 is treated as word.
- M_Unsigned  in  1  zero-extend sub-word loads.
- M_ALU_out  in  32  effective address, or ALU result for non-memory instructions.
- M_Rt_data  in  32  store data.
- M_WR  in  5  destination register.
- DM_req  out  1  memory request, registered.
- DM_we  out  1  1 = write.
- DM_addr  out  32  word address: M_ALU_out with bits [1:0] forced to 00.
- DM_be  out  4  byte enables.
- DM_wdata  out  32  lane-replicated store data.
- DM_ack  in  1  memory completion, valid only while DM_req=1.
- DM_rdata  in  32  read data, valid with DM_ack.
- M_WBWrite  out  1  write enable for M_WB.
- M_WB_MemtoReg  out  1  = M_MemtoReg.
- M_WB_RegWrite  out  1  = M_RegWrite, gated off on a fault.
- M_DM_Read_Data  out  32  registered, formatted load result.
- M_WD_out  out  32  = M_ALU_out.
- M_WR_out  out  5  = M_WR.
- mem_stall  out  1  freezes PC, IF/ID, ID/EX and EX/M.
- mem_fault  out  1  one-cycle pulse in the faulting instruction's advance cycle.
- fault_cause  out  2  01 misaligned, 10 timeout, 00 none; valid while mem_fault=1.

Behaviour:
- Reset (rst=0, asynchronous, any state including BUSY):
  - state goes to IDLE.
  - DM_req, DM_we, DM_addr, DM_be, DM_wdata, M_DM_Read_Data, the timeout counter and the error flag all go to 0.
  - DM_req drops immediately, without waiting for a clock edge.
- mem_op = M_MemRead | M_MemWrite. When both are high, the access is treated as a store.
- Misalignment: half with addr[0]=1, or word with addr[1:0]!=0.
  - No memory request is issued and no stall occurs.
  - mem_fault=1 and fault_cause=01 in that same cycle.
  - M_WB_RegWrite=0.
- States:
  - IDLE:
    - For an aligned mem_op: mem_stall=1 and M_WBWrite=0. On the next edge, register DM_req=1 with DM_we, DM_addr, DM_be and DM_wdata; clear the counter; go to BUSY.
    - Otherwise: mem_stall=0, M_WBWrite=1, single-cycle passthrough; M_DM_Read_Data holds its value.
  - BUSY:
    - mem_stall=1 and M_WBWrite=0. DM_* outputs stay stable. The counter increments each cycle.
    - If DM_ack=1: capture the formatted DM_rdata into M_DM_Read_Data (loads only; stores leave it unchanged); DM_req goes to 0; go to DONE.
    - Else if counter = TIMEOUT-1: DM_req goes to 0; set the error flag; go to DONE.
    - If DM_ack=1 arrives in the same cycle the timeout is reached, the ack wins.
  - DONE:
    - mem_stall=0 and M_WBWrite=1; the instruction advances.
    - If the error flag is set: mem_fault=1, fault_cause=10, M_WB_RegWrite=0; clear the flag. Next state is IDLE.
- DM_ack outside BUSY is ignored.
- While M_WBWrite=0, M_WB holds its contents. The repeated writeback of an unchanged register is idempotent.
- Latency: non-memory instructions take 1 cycle. A memory access takes 3 + (number of BUSY cycles before ack) − 1, i.e. a minimum of 3 cycles.
- Lanes are little-endian; k = addr[1:0].
  - Byte: DM_be = 1<<k; data is DM_rdata[8k+7:8k]; DM_wdata = the store byte replicated ×4.
  - Half: addr[1]=0 selects DM_be=0011 and lanes [15:0]; addr[1]=1 selects DM_be=1100 and lanes [31:16]; DM_wdata = the halfword replicated ×2.
  - Word: DM_be=1111.
  - Sub-word loads are sign-extended, or zero-extended when M_Unsigned=1.

Test Plan:
- Reset during BUSY (DM_req=1): drive rst=0 -> DM_req=0 immediately, outputs zero, IDLE; after release an ADD passes with M_WBWrite=1 in 1 cycle.
- Signed byte load from addr 0x103, DM_rdata=0x80FF_FFFF, ack on the 2nd BUSY cycle -> DM_be=1000, DM_addr=0x100, M_DM_Read_Data=0xFFFF_FF80, mem_stall high 3 cycles.
- Unsigned half load from addr 0x202, DM_rdata=0x8001_1234 -> M_DM_Read_Data=0x0000_8001; signed load of the same -> 0xFFFF_8001.
- Byte store 0x0000_00AB to addr 0x301 -> DM_we=1, DM_be=0010, DM_wdata=0xABAB_ABAB, DM_addr=0x300.
- Word load from 0x402 -> no DM_req, mem_fault=1 with fault_cause=01, M_WB_RegWrite=0, no stall.
- Load with DM_ack held at 0 for TIMEOUT=16 cycles -> DM_req drops after 16 BUSY cycles, then DONE with mem_fault=1, fault_cause=10, M_WB_RegWrite=0; a second run with ack arriving exactly on cycle 16 completes normally with no fault.
